// File: rtl/demux_rr_scheduler.sv
// Round-robin burst scheduler steering one valid/ready stream onto four lanes, BURST_LEN beats per grant.
// Optional stall abort is compiled in with DEMUX_SCHED_TIMEOUT_EN.
module demux_rr_scheduler #(
  parameter int DATA_W      = 8,
  parameter int BURST_LEN   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            ch_en,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DATA_W-1:0]   out_data,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  output logic [1:0]            sel,
  output logic                  busy,
  output logic [7:0]            beat_cnt,
`ifdef DEMUX_SCHED_TIMEOUT_EN
  output logic                  timeout,
`endif
  output logic [1:0]            dbg_state
);

  // Handshake: a beat transfers on a cycle where in_valid && in_ready; in_ready
  // mirrors out_ready of the granted lane only in XFER, so the producer sees the
  // consumer directly with no buffering.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_XFER  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  last_sel_q, last_sel_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic        beat;

`ifdef DEMUX_SCHED_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               timeout_q, timeout_d;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  // Nearest enabled channel after last, wrapping; descending scan lets the closest win.
  function automatic logic [1:0] pick(input logic [1:0] last, input logic [3:0] en);
    logic [1:0] c;
    pick = last;
    for (int i = 4; i >= 1; i--) begin
      c = last + 2'(i);
      if (en[c]) pick = c;
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_sel_d = last_sel_q;
    beat_cnt_d = beat_cnt_q;
    in_ready   = 1'b0;
    out_valid  = '0;
    out_data   = '0;
    beat       = 1'b0;
`ifdef DEMUX_SCHED_TIMEOUT_EN
    stall_d    = stall_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && (ch_en != 4'b0000)) begin
          state_d    = S_GRANT;
          sel_d      = pick(last_sel_q, ch_en);
          beat_cnt_d = 8'd0;
        end
      end
      S_GRANT: begin
        state_d    = S_XFER;
        beat_cnt_d = 8'd0;
`ifdef DEMUX_SCHED_TIMEOUT_EN
        stall_d    = '0;
`endif
      end
      S_XFER: begin
        in_ready = out_ready[sel_q];
        for (int k = 0; k < 4; k++) begin
          if (2'(k) == sel_q) begin
            out_valid[k]                   = in_valid;
            out_data[k*DATA_W +: DATA_W]   = in_data;
          end
        end
        beat = in_valid && in_ready;
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (beat_cnt_q + 8'd1 == 8'(BURST_LEN)) begin
            state_d    = S_IDLE;
            last_sel_d = sel_q;
          end
`ifdef DEMUX_SCHED_TIMEOUT_EN
          stall_d = '0;
        end else if (32'(stall_q) + 32'd1 == TIMEOUT_CYC) begin
          state_d    = S_IDLE;
          last_sel_d = sel_q;
          timeout_d  = 1'b1;
          stall_d    = '0;
        end else begin
          stall_d = stall_q + STALL_W'(1);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sel_q      <= 2'd0;
      last_sel_q <= 2'd3;
      beat_cnt_q <= 8'd0;
`ifdef DEMUX_SCHED_TIMEOUT_EN
      stall_q    <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_sel_q <= last_sel_d;
      beat_cnt_q <= beat_cnt_d;
`ifdef DEMUX_SCHED_TIMEOUT_EN
      stall_q    <= stall_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign sel       = sel_q;
  assign busy      = (state_q != S_IDLE);
  assign beat_cnt  = beat_cnt_q;
  assign dbg_state = state_q;
`ifdef DEMUX_SCHED_TIMEOUT_EN
  assign timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Randomized scoreboard bench for demux_rr_scheduler: driver pushes expected {lane,data}
// beats, a negedge monitor pops and compares on every accepted beat.
module tb_demux_rr_scheduler;

  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 4;
  localparam int W         = 2 + DATA_W;

  logic                 clk;
  logic                 rst_n;
  logic [3:0]           ch_en;
  logic [DATA_W-1:0]    in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [4*DATA_W-1:0]  out_data;
  logic [3:0]           out_valid;
  logic [3:0]           out_ready;
  logic [1:0]           sel;
  logic                 busy;
  logic [7:0]           beat_cnt;
  logic [1:0]           dbg_state;
`ifdef DEMUX_SCHED_TIMEOUT_EN
  logic                 timeout;
`endif

  demux_rr_scheduler #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_en     (ch_en),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy),
    .beat_cnt  (beat_cnt),
`ifdef DEMUX_SCHED_TIMEOUT_EN
    .timeout   (timeout),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  last_ch = 3;
  bit  rand_ready = 1'b0;
  bit  strict_gap = 1'b0;

  task automatic check_eq(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference rule: first enabled channel after the last one, wrapping mod 4.
  function automatic int next_ch(input int last, input logic [3:0] m);
    for (int i = 1; i <= 4; i++)
      if (m[(last + i) % 4]) return (last + i) % 4;
    return last;
  endfunction

  // ---------------- random lane backpressure ----------------
  initial begin
    out_ready = 4'hF;
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready)
        out_ready = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input int lane, input logic [DATA_W-1:0] d, input int max_gap);
    int n;
    int gap;
    exp_q.push_back({2'(lane), d});
    gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 200) begin
        check_eq("beat_wait_expired", n, 0);
        break;
      end
    end
  endtask

  task automatic run_burst(input logic [3:0] mask, input logic [3:0] mid_mask, input int max_gap);
    int ch;
    ch = next_ch(last_ch, mask);
    ch_en = mask;
    for (int b = 0; b < BURST_LEN; b++) begin
      send_beat(ch, DATA_W'($urandom_range(0, 255)), max_gap);
      if (b == 0) ch_en = mid_mask;
    end
    in_valid = 1'b0;
    last_ch = ch;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_sel"},       sel, 0);
    check_eq({tag, "_beat_cnt"},  beat_cnt, 0);
    check_eq({tag, "_busy"},      busy, 0);
    check_eq({tag, "_in_ready"},  in_ready, 0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_data"},  out_data, 0);
`ifdef DEMUX_SCHED_TIMEOUT_EN
    check_eq({tag, "_timeout"},   timeout, 0);
`endif
  endtask

  // ---------------- monitor / scoreboard ----------------
  int cyc = 0;
  int last_beat_cyc = 0;
  int mon_k = 0;
  bit have_prev = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0]          e;
    logic [4*DATA_W-1:0]   ed;
    int                    lane;
    cyc++;
    if (!rst_n) begin
      mon_k     = 0;
      have_prev = 1'b0;
    end else if (in_valid && in_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_beat", 1, 0);
      end else begin
        e    = exp_q.pop_front();
        lane = int'(e[W-1 -: 2]);
        ed   = '0;
        ed[lane*DATA_W +: DATA_W] = e[DATA_W-1:0];
        check_eq("lane_valid", out_valid, 64'(4'b0001 << lane));
        check_eq("lane_data",  out_data, ed);
        check_eq("sel",        sel, lane);
        check_eq("beat_cnt",   beat_cnt, mon_k);
        if (mon_k == 0 && have_prev) begin
          if (strict_gap) check_eq("burst_gap", cyc - last_beat_cyc, 3);
          else            check_eq("burst_gap_min", (cyc - last_beat_cyc) >= 3, 1);
        end
        last_beat_cyc = cyc;
        have_prev     = 1'b1;
        mon_k         = (mon_k + 1) % BURST_LEN;
      end
    end else if (!busy) begin
      check_eq("idle_quiet", {out_valid, in_ready}, 0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n    = 1'b0;
    ch_en    = 4'h0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fairness with every channel enabled, continuous data, full ready.
    strict_gap = 1'b1;
    for (int i = 0; i < 5; i++) run_burst(4'hF, 4'hF, 0);
    strict_gap = 1'b0;

    // Masked rotation over channels 1 and 3.
    for (int i = 0; i < 3; i++) run_burst(4'b1010, 4'b1010, 0);

    // Backpressure on lane 2 after its second beat.
    ch_en = 4'b0100;
    send_beat(2, 8'hA0, 0);
    send_beat(2, 8'hA1, 0);
    out_ready = 4'b1011;
    in_valid  = 1'b1;
    in_data   = 8'hA2;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("stall_in_ready", in_ready, 0);
      check_eq("stall_beat_cnt", beat_cnt, 2);
      @(posedge clk);
      #1;
    end
    out_ready = 4'hF;
    send_beat(2, 8'hA2, 0);
    send_beat(2, 8'hA3, 0);
    in_valid = 1'b0;
    last_ch  = 2;

    // Mask change mid-burst is ignored; next grant follows the new mask.
    run_burst(4'b0010, 4'b0101, 0);
    run_burst(4'b0101, 4'b0101, 0);

    // Random masks, random valid gaps, random lane readiness.
    rand_ready = 1'b1;
    for (int i = 0; i < 25; i++)
      run_burst(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), 2);
    rand_ready = 1'b0;
    @(posedge clk);
    #3;
    out_ready = 4'hF;

    // Reset after beat 2 of a burst to channel 3.
    ch_en = 4'b1000;
    send_beat(3, DATA_W'($urandom_range(0, 255)), 0);
    send_beat(3, DATA_W'($urandom_range(0, 255)), 0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    rst_n   = 1'b1;
    last_ch = 3;
    run_burst(4'hF, 4'hF, 0);

`ifdef DEMUX_SCHED_TIMEOUT_EN
    // Lane 0 never ready: burst aborts after the stall limit.
    out_ready = 4'b1110;
    ch_en     = 4'b0001;
    in_data   = 8'h55;
    in_valid  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 20);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!timeout && n < 40);
    in_valid = 1'b0;
    check_eq("timeout_latency", n, 17);
    @(negedge clk);
    check_eq("timeout_pulse_width", timeout, 0);
    out_ready = 4'hF;
    last_ch   = 0;
    run_burst(4'hF, 4'hF, 0);
`endif

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check_eq("scoreboard_drained", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
